// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: runs the CPU for RUN_CYCLES, then streams a window of RAM words out over valid/ready
module mem_dump_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 16,
    parameter int unsigned RUN_CYCLES = 20,
    parameter int          DUMP_BASE  = 0,
    parameter int          DUMP_COUNT = 9,
    parameter int          RD_LATENCY = 1
) (
    input  logic              clock_50_b7a,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              cpu_run,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_count
);
    localparam int                WL_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(DUMP_BASE);
    localparam logic [WL_W-1:0]   COUNT   = WL_W'(DUMP_COUNT);
    localparam logic [WL_W-1:0]   ONE     = WL_W'(1);
    localparam logic [2:0]        LAT_END = 3'(RD_LATENCY - 1);
    localparam logic [31:0]       RUN_END = RUN_CYCLES - 1;

    typedef enum logic [2:0] {IDLE, RUN, READ, WAIT, OUT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [2:0]        lat_q, lat_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              cpu_run_q, cpu_run_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Sequencing, counters, and output values decoded from the next state so outputs stay registered
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        words_left_d  = words_left_q;
        lat_d         = lat_q;
        cycle_count_d = cycle_count_q;
        if (abort) state_d = IDLE;
        else case (state_q)
            IDLE, DONE: if (start) begin
                state_d       = RUN;
                cycle_count_d = '0;
                addr_d        = BASE;
                words_left_d  = COUNT;
            end
            RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (cycle_count_q == RUN_END) state_d = (DUMP_COUNT == 0) ? DONE : READ;
            end
            READ: begin
                state_d = WAIT;
                lat_d   = '0;
            end
            WAIT: if (lat_q == LAT_END) state_d = OUT; else lat_d = lat_q + 3'd1;
            OUT: if (dump_ready) begin
                addr_d       = addr_q + ADDR_W'(1);
                words_left_d = words_left_q - ONE;
                state_d      = (words_left_q == ONE) ? DONE : READ;
            end
            default: state_d = IDLE;
        endcase
        cpu_run_d    = state_d == RUN;
        mem_rd_en_d  = state_d == READ;
        mem_addr_d   = (state_d == READ) ? addr_d : '0;
        dump_valid_d = state_d == OUT;
        dump_addr_d  = (state_d != OUT) ? '0 : (state_q == OUT) ? dump_addr_q : addr_q;
        dump_data_d  = (state_d != OUT) ? '0 : (state_q == OUT) ? dump_data_q : mem_rd_data;
        dump_last_d  = (state_d == OUT) && ((state_q == OUT) ? dump_last_q : words_left_q == ONE);
        busy_d       = state_d inside {RUN, READ, WAIT, OUT};
        done_d       = state_d == DONE;
    end

    // State register; reset drops every output at once so no handshake can complete
    always_ff @(posedge clock_50_b7a or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= BASE;
            words_left_q  <= COUNT;
            lat_q         <= '0;
            cycle_count_q <= '0;
            cpu_run_q     <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            dump_valid_q  <= 1'b0;
            dump_addr_q   <= '0;
            dump_data_q   <= '0;
            dump_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            words_left_q  <= words_left_d;
            lat_q         <= lat_d;
            cycle_count_q <= cycle_count_d;
            cpu_run_q     <= cpu_run_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            dump_valid_q  <= dump_valid_d;
            dump_addr_q   <= dump_addr_d;
            dump_data_q   <= dump_data_d;
            dump_last_q   <= dump_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign cpu_run     = cpu_run_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_addr   = dump_addr_q;
    assign dump_data   = dump_data_q;
    assign dump_last   = dump_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: four controller instances (default, latency 3, wrapping window, empty window) against a dump model
module tb_mem_dump_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start [N], abort [N], dump_ready [N];
    logic        cpu_run [N], mem_rd_en [N], dump_valid [N], dump_last [N], busy [N], done [N];
    logic [7:0]  mem_addr [N], dump_addr [N];
    logic [15:0] mem_rd_data [N], dump_data [N];
    logic [31:0] cycle_count [N];
    logic [15:0] pipe [N][4];

    int base_of [N] = '{0, 0, 254, 0};
    int cnt_of  [N] = '{9, 9, 4, 0};

    typedef struct packed {
        logic        last;
        logic [7:0]  addr;
        logic [15:0] data;
    } word_t;

    int    checks = 0, errors = 0;
    word_t got[$];
    int    gaps[$];
    int    run_cyc, rd_seen, valid_seen, overlap, unstable, first_cc, finished;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign mem_rd_data[g] = pipe[g][g == 1 ? 2 : 0];
        mem_dump_ctrl #(
            .RD_LATENCY(g == 1 ? 3 : 1),
            .DUMP_BASE (g == 2 ? 254 : 0),
            .DUMP_COUNT(g == 2 ? 4 : g == 3 ? 0 : 9)
        ) u_dut (
            .clock_50_b7a(clk),
            .reset       (reset),
            .start       (start[g]),
            .abort       (abort[g]),
            .cpu_run     (cpu_run[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_addr    (mem_addr[g]),
            .mem_rd_data (mem_rd_data[g]),
            .dump_valid  (dump_valid[g]),
            .dump_ready  (dump_ready[g]),
            .dump_addr   (dump_addr[g]),
            .dump_data   (dump_data[g]),
            .dump_last   (dump_last[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .cycle_count (cycle_count[g])
        );
    end

    // RAM holding mem[a] = 0x1000 + a; returns junk unless a read was actually issued
    always @(posedge clk) begin
        for (int d = 0; d < N; d++) begin
            pipe[d][0] <= mem_rd_en[d] ? 16'h1000 + 16'(mem_addr[d]) : 16'($urandom);
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end

    function automatic word_t exp_word(input int base, input int cnt, input int k);
        logic [7:0] a;
        a = 8'((base + k) % 256);
        return {k == cnt - 1, a, 16'h1000 + 16'(a)};
    endfunction

    // Pulse start on instance d and record everything it does until done or the cycle budget runs out
    task automatic run_dump(input int d, input bit rnd);
        int    last_acc = -1;
        bit    held = 1'b0;
        word_t h = '0;
        got.delete();
        gaps.delete();
        run_cyc = 0; rd_seen = 0; valid_seen = 0; overlap = 0; unstable = 0; finished = 0;
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        first_cc = int'(cycle_count[d]);
        for (int c = 0; c < 3000 && finished == 0; c++) begin
            run_cyc += int'(cpu_run[d]);
            if (mem_rd_en[d]) begin
                rd_seen++;
                if (cpu_run[d]) overlap++;
            end
            if (dump_valid[d]) valid_seen++;
            if (held && (!dump_valid[d] || {dump_last[d], dump_addr[d], dump_data[d]} !== h)) unstable++;
            dump_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = dump_valid[d] && !dump_ready[d];
            h = {dump_last[d], dump_addr[d], dump_data[d]};
            if (dump_valid[d] && dump_ready[d]) begin
                got.push_back(h);
                if (last_acc >= 0) gaps.push_back(c - last_acc);
                last_acc = c;
            end
            if (done[d]) finished = 1; else @(negedge clk);
        end
        dump_ready[d] = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({cpu_run[d], mem_rd_en[d], mem_addr[d], dump_valid[d], dump_addr[d], dump_data[d],
                 dump_last[d], busy[d], done[d], cycle_count[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b cc=%0d, required all zero", d, busy[d], done[d], cycle_count[d]);
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || cpu_run[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b cpu_run=%b, required 0 0", busy[0], cpu_run[0]);
        end
    endtask

    task automatic test_basic;
        run_dump(0, 1'b0);
        checks++;
        if (finished != 1) begin errors++; $display("FAIL basic_done: got finished=%0d, required 1", finished); end
        checks++;
        if (run_cyc != 20) begin errors++; $display("FAIL basic_run_cycles: got %0d, required 20", run_cyc); end
        checks++;
        if (first_cc != 0) begin errors++; $display("FAIL basic_first_cc: got %0d, required 0", first_cc); end
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL basic_overlap: got %0d, required 0", overlap); end
        checks++;
        if (got.size() != 9) begin errors++; $display("FAIL basic_word_count: got %0d, required 9", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_word(0, 9, k)) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h, required %h", k, got[k], exp_word(0, 9, k));
            end
        end
        foreach (gaps[k]) begin
            checks++;
            if (gaps[k] != 3) begin errors++; $display("FAIL basic_gap[%0d]: got %0d, required 3", k, gaps[k]); end
        end
        checks++;
        if (cycle_count[0] !== 32'd20 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: got cc=%0d done=%b busy=%b, required 20 1 0", cycle_count[0], done[0], busy[0]);
        end
    endtask

    task automatic test_latency;
        run_dump(1, 1'b0);
        checks++;
        if (gaps.size() != 8) begin errors++; $display("FAIL lat3_gap_count: got %0d, required 8", gaps.size()); end
        foreach (gaps[k]) begin
            checks++;
            if (gaps[k] != 5) begin errors++; $display("FAIL lat3_gap[%0d]: got %0d, required 5", k, gaps[k]); end
        end
        run_dump(1, 1'b1);
        checks++;
        if (finished != 1 || got.size() != 9) begin
            errors++;
            $display("FAIL lat3_rand_count: got finished=%0d words=%0d, required 1 9", finished, got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_word(0, 9, k)) begin
                errors++;
                $display("FAIL lat3_rand_word[%0d]: got %h, required %h", k, got[k], exp_word(0, 9, k));
            end
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL lat3_stable: got %0d changes while stalled, required 0", unstable); end
    endtask

    task automatic test_wrap;
        run_dump(2, 1'b1);
        checks++;
        if (finished != 1 || got.size() != cnt_of[2]) begin
            errors++;
            $display("FAIL wrap_count: got finished=%0d words=%0d, required 1 %0d", finished, got.size(), cnt_of[2]);
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_word(base_of[2], cnt_of[2], k)) begin
                errors++;
                $display("FAIL wrap_word[%0d]: got %h, required %h", k, got[k], exp_word(base_of[2], cnt_of[2], k));
            end
        end
    endtask

    task automatic test_zero_count;
        run_dump(3, 1'b0);
        checks++;
        if (finished != 1 || run_cyc != 20) begin
            errors++;
            $display("FAIL zero_run: got finished=%0d run=%0d, required 1 20", finished, run_cyc);
        end
        checks++;
        if (rd_seen != 0 || valid_seen != 0) begin
            errors++;
            $display("FAIL zero_no_access: got reads=%0d valids=%0d, required 0 0", rd_seen, valid_seen);
        end
        checks++;
        if (cycle_count[3] !== 32'd20) begin errors++; $display("FAIL zero_cc: got %0d, required 20", cycle_count[3]); end
    endtask

    task automatic test_abort;
        int seen = 0;
        abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0;
        checks++;
        if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_from_done: got done=%b, required 0", done[0]); end
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (cpu_run[0] && cycle_count[0] == 32'd5) seen = 1; else @(negedge clk);
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL abort_reach_cycle5: got timeout, required cycle_count 5"); end
        abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0;
        checks++;
        if (cpu_run[0] !== 1'b0 || busy[0] !== 1'b0 || cycle_count[0] !== 32'd5) begin
            errors++;
            $display("FAIL abort_run: got cpu_run=%b busy=%b cc=%0d, required 0 0 5", cpu_run[0], busy[0], cycle_count[0]);
        end
        start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0; abort[0] = 1'b0;
        checks++;
        if (cpu_run[0] !== 1'b0 || busy[0] !== 1'b0 || cycle_count[0] !== 32'd5) begin
            errors++;
            $display("FAIL abort_beats_start: got cpu_run=%b busy=%b cc=%0d, required 0 0 5", cpu_run[0], busy[0], cycle_count[0]);
        end
        run_dump(0, 1'b0);
        checks++;
        if (first_cc != 0 || run_cyc != 20 || got.size() != 9) begin
            errors++;
            $display("FAIL abort_restart: got first_cc=%0d run=%0d words=%0d, required 0 20 9", first_cc, run_cyc, got.size());
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0, bad = 0;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0; dump_ready[0] = 1'b0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (dump_valid[0]) seen = 1; else @(negedge clk);
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL rst_mid_reach_out: got timeout, required dump_valid"); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_run[0], mem_rd_en[0], mem_addr[0], dump_valid[0], dump_addr[0], dump_data[0],
             dump_last[0], busy[0], done[0], cycle_count[0]} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got valid=%b busy=%b cc=%0d, required all zero", dump_valid[0], busy[0], cycle_count[0]);
        end
        @(negedge clk); reset = 1'b1; dump_ready[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (dump_valid[0] || busy[0]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", bad); end
        run_dump(0, 1'b0);
        checks++;
        if (got.size() != 9 || got[0] !== exp_word(0, 9, 0)) begin
            errors++;
            $display("FAIL rst_mid_restart: got words=%0d first=%h, required 9 %h", got.size(), got[0], exp_word(0, 9, 0));
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
            dump_ready[d] = 1'b1;
        end
        test_reset;
        test_basic;
        test_latency;
        test_wrap;
        test_zero_count;
        test_abort;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
